falafel_lsu: RTL and testbench
==============================

FALAFEL_LSU -- requirements
Module: falafel_lsu

Interface
REQ-001 Parameter: LOCK_ADDR, default 64'h0, word address of the allocator lock word.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-high.
REQ-004 req_i  input  header_data_req_t  request from the allocator core: header_data {addr, size, next_addr}, val, lsu_op.
REQ-005 req_ready_o  output  1  LSU can accept a request; a request is accepted in a cycle where req_i.val and req_ready_o are both 1.
REQ-006 rsp_o  output  header_data_rsp_t  response: header_data, with val used as the response-valid/success flag (see REQ-019).
REQ-007 rsp_valid_o  output  1  response present; held until rsp_ready_i=1.
REQ-008 rsp_ready_i  input  1  consumer accepts the response.
REQ-009 mem_req_o  output  1  memory request; mem_we_o, mem_addr_o and mem_wdata_o are held stable while mem_req_o=1 and mem_gnt_i=0.
REQ-010 mem_we_o  output  1  1=write, 0=read.
REQ-011 mem_addr_o  output  64  byte address, word aligned.
REQ-012 mem_wdata_o  output  64  write data.
REQ-013 mem_gnt_i  input  1  memory accepts the request in a cycle where mem_req_o and mem_gnt_i are both 1.
REQ-014 mem_rvalid_i  input  1  exactly one pulse per accepted request, for reads and writes, at least 1 cycle after the grant.
REQ-015 mem_rdata_i  input  64  read data, valid when mem_rvalid_i=1.

Function
REQ-016 Outstanding limits: at most one request in flight and at most one memory transaction outstanding; mem_req_o stays 0 from the grant until the matching mem_rvalid_i.
REQ-017 req_ready_o = 1 only in IDLE, and only when no response is pending.
REQ-018 States: IDLE, LOCK_RD, LOCK_WR, RD_SIZE, RD_NEXT, WR_SIZE, WR_NEXT, WR_LINK, RSP. Each memory state issues one access, waits for mem_rvalid_i, then advances.
REQ-019 Response rules:
- rsp_o.val=1 on success, 0 on error.
- rsp_o.header_data echoes the request except where an operation overwrites fields.
- Every accepted request produces exactly one response.
REQ-020 LOCK: LOCK_RD reads LOCK_ADDR.
- rdata != 0: re-issue the read the next cycle (spin, unbounded).
- rdata == 0: LOCK_WR writes 64'h1 to LOCK_ADDR, then RSP.
REQ-021 UNLOCK: write 64'h0 to LOCK_ADDR, then RSP.
REQ-022 LOAD: RD_SIZE reads addr, RD_NEXT reads addr+8; respond with {addr, size=first rdata, next_addr=second rdata}.
REQ-023 SET_INSERT_ADDR: no memory access; latch insert_addr=addr and set insert_valid=1; RSP in the next cycle.
REQ-024 INSERT: WR_SIZE writes size to addr, WR_NEXT writes next_addr to addr+8, WR_LINK writes addr to insert_addr+8, then RSP.
REQ-025 DELETE: writes next_addr to addr+8 (addr = predecessor), then RSP.
REQ-026 Address arithmetic: 64-bit modulo 2^64; addr+8 wraps silently with no error.
REQ-027 Misalignment: any LOAD/INSERT/DELETE with addr[2:0] != 0 responds val=0 with no memory access.
REQ-028 INSERT with insert_valid=0 responds val=0 with no memory access.
REQ-029 Response timing: rsp_valid_o rises the cycle after the last mem_rvalid_i (or after the decision for no-access ops); it clears on rsp_ready_i; IDLE is re-entered in the same cycle.
REQ-030 rsp_ready_i=0: rsp_o is held stable and no new request is accepted.
REQ-031 Unknown lsu_op: responds val=0 with no memory access.

Reset
REQ-032 Asynchronous reset values: state=IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rsp_valid_o=0, rsp_o=0, insert_addr=0, insert_valid=0.
REQ-033 Reset mid-transaction abandons the operation with no response; any mem_rvalid_i arriving after reset release for a pre-reset request is ignored.
REQ-034 req_ready_o=1 from the first cycle after reset release.

Verification
REQ-035 LOAD addr=0x100, memory [0x100]=0x40, [0x108]=0x200 -> two reads (0x100, 0x108); rsp {0x100, 0x40, 0x200}, val=1.
REQ-036 LOCK with [LOCK_ADDR] returning 1, 1, then 0 -> three reads then one write of 1; single response val=1.
REQ-037 SET_INSERT_ADDR 0x300, then INSERT {0x500, 0x80, 0x600} -> writes [0x500]=0x80, [0x508]=0x600, [0x308]=0x500 in order; val=1.
REQ-038 INSERT immediately after reset -> val=0, zero memory requests.
REQ-039 LOAD addr=0x104 -> val=0, zero memory requests; rsp_ready_i held 0 for 5 cycles -> rsp_o stable, req_ready_o=0 throughout.
REQ-040 rst_i asserted while waiting for mem_rvalid_i of a LOAD -> all outputs at reset values; after release, a stale mem_rvalid_i is ignored and the next request completes normally.

Source files
------------

// File: rtl/falafel_lsu.sv
// rtl/falafel_lsu.sv - allocator load/store unit: lock, header load/insert/delete over one memory port
// req_i = {addr[63:0], size[63:0], next_addr[63:0], val, lsu_op[2:0]}; rsp_o = {addr, size, next_addr, val}.
module falafel_lsu #(
  parameter logic [63:0] LOCK_ADDR = 64'h0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [195:0] req_i,
  output logic         req_ready_o,
  output logic [192:0] rsp_o,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [63:0]  mem_addr_o,
  output logic [63:0]  mem_wdata_o,
  input  logic         mem_gnt_i,
  input  logic         mem_rvalid_i,
  input  logic [63:0]  mem_rdata_i
);
  localparam logic [2:0] OP_LOCK    = 3'd0;
  localparam logic [2:0] OP_UNLOCK  = 3'd1;
  localparam logic [2:0] OP_LOAD    = 3'd2;
  localparam logic [2:0] OP_SET_INS = 3'd3;
  localparam logic [2:0] OP_INSERT  = 3'd4;
  localparam logic [2:0] OP_DELETE  = 3'd5;

  typedef enum logic [3:0] {
    IDLE, LOCK_RD, LOCK_WR, RD_SIZE, RD_NEXT, WR_SIZE, WR_NEXT, WR_LINK, RSP
  } state_t;

  state_t       state_q;
  logic [2:0]   op_q;
  logic [63:0]  addr_q, size_q, next_q, ins_addr_q;
  logic         ins_valid_q, wait_q, mem_req_q, mem_we_q, rsp_valid_q;
  logic [63:0]  mem_addr_q, mem_wdata_q;
  logic [192:0] rsp_q;

  logic [63:0]  req_addr, req_size, req_next;
  logic [2:0]   req_op;
  logic         req_val, misaligned, accept;
  logic [192:0] done_rsp;

  assign req_addr    = req_i[195:132];
  assign req_size    = req_i[131:68];
  assign req_next    = req_i[67:4];
  assign req_val     = req_i[3];
  assign req_op      = req_i[2:0];
  assign misaligned  = (req_addr[2:0] != 3'b000);
  assign req_ready_o = (state_q == IDLE) && !rsp_valid_q;
  assign accept      = req_val && req_ready_o;
  assign done_rsp    = {addr_q, size_q, next_q, 1'b1};

  assign rsp_o       = rsp_q;
  assign rsp_valid_o = rsp_valid_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      op_q        <= 3'd0;
      addr_q      <= 64'h0;
      size_q      <= 64'h0;
      next_q      <= 64'h0;
      ins_addr_q  <= 64'h0;
      ins_valid_q <= 1'b0;
      wait_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'h0;
      mem_wdata_q <= 64'h0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          addr_q <= req_addr;
          size_q <= req_size;
          next_q <= req_next;
          op_q   <= req_op;
          rsp_q  <= {req_addr, req_size, req_next, 1'b0};
          // Default is an immediate error response; memory ops override below.
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
          case (req_op)
            OP_LOCK: begin
              state_q <= LOCK_RD; rsp_valid_q <= 1'b0;
              mem_req_q <= 1'b1; mem_we_q <= 1'b0; mem_addr_q <= LOCK_ADDR;
            end
            OP_UNLOCK: begin
              state_q <= LOCK_WR; rsp_valid_q <= 1'b0;
              mem_req_q <= 1'b1; mem_we_q <= 1'b1; mem_addr_q <= LOCK_ADDR; mem_wdata_q <= 64'h0;
            end
            OP_LOAD: if (!misaligned) begin
              state_q <= RD_SIZE; rsp_valid_q <= 1'b0;
              mem_req_q <= 1'b1; mem_we_q <= 1'b0; mem_addr_q <= req_addr;
            end
            OP_SET_INS: begin
              ins_addr_q <= req_addr; ins_valid_q <= 1'b1; rsp_q[0] <= 1'b1;
            end
            OP_INSERT: if (!misaligned && ins_valid_q) begin
              state_q <= WR_SIZE; rsp_valid_q <= 1'b0;
              mem_req_q <= 1'b1; mem_we_q <= 1'b1; mem_addr_q <= req_addr; mem_wdata_q <= req_size;
            end
            OP_DELETE: if (!misaligned) begin
              state_q <= WR_NEXT; rsp_valid_q <= 1'b0;
              mem_req_q <= 1'b1; mem_we_q <= 1'b1;
              mem_addr_q <= req_addr + 64'd8; mem_wdata_q <= req_next;
            end
            default: ;
          endcase
        end
        RSP: if (rsp_ready_i) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          if (mem_req_q) begin
            if (mem_gnt_i) begin
              mem_req_q <= 1'b0;
              wait_q    <= 1'b1;
            end
          end else if (wait_q && mem_rvalid_i) begin
            wait_q <= 1'b0;
            case (state_q)
              LOCK_RD: if (mem_rdata_i != 64'h0) begin
                mem_req_q <= 1'b1;
              end else begin
                state_q <= LOCK_WR;
                mem_req_q <= 1'b1; mem_we_q <= 1'b1; mem_wdata_q <= 64'h1;
              end
              RD_SIZE: begin
                size_q <= mem_rdata_i; state_q <= RD_NEXT;
                mem_req_q <= 1'b1; mem_addr_q <= addr_q + 64'd8;
              end
              RD_NEXT: begin
                rsp_q <= {addr_q, size_q, mem_rdata_i, 1'b1};
                rsp_valid_q <= 1'b1; state_q <= RSP;
              end
              WR_SIZE: begin
                state_q <= WR_NEXT;
                mem_req_q <= 1'b1; mem_addr_q <= addr_q + 64'd8; mem_wdata_q <= next_q;
              end
              WR_NEXT: if (op_q == OP_INSERT) begin
                state_q <= WR_LINK;
                mem_req_q <= 1'b1; mem_addr_q <= ins_addr_q + 64'd8; mem_wdata_q <= addr_q;
              end else begin
                rsp_q <= done_rsp; rsp_valid_q <= 1'b1; state_q <= RSP;
              end
              LOCK_WR, WR_LINK: begin
                rsp_q <= done_rsp; rsp_valid_q <= 1'b1; state_q <= RSP;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_falafel_lsu.sv
// tb/tb_falafel_lsu.sv - scoreboard bench for falafel_lsu with a behavioural memory and reference model
module tb_falafel_lsu;
  localparam logic [63:0] LOCK = 64'h0;
  localparam logic [2:0] OP_LOCK = 3'd0, OP_UNLOCK = 3'd1, OP_LOAD = 3'd2,
                         OP_SET = 3'd3, OP_INSERT = 3'd4, OP_DELETE = 3'd5;

  logic         clk, rst_i;
  logic [195:0] req_i;
  logic         req_ready_o;
  logic [192:0] rsp_o;
  logic         rsp_valid_o, rsp_ready_i;
  logic         mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [63:0]  mem_addr_o, mem_wdata_o, mem_rdata_i;

  falafel_lsu #(.LOCK_ADDR(LOCK)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_ready_o(req_ready_o),
    .rsp_o(rsp_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  int total = 0, bad = 0, grants = 0, stale_req = 0;
  logic rsp_hold = 1'b0, hold_rv = 1'b0;
  logic [63:0]  mem[logic [63:0]];
  logic [63:0]  ref_mem[logic [63:0]];
  logic [63:0]  spin_q[$];
  logic [128:0] exp_mem[$];
  logic [192:0] exp_rsp[$];
  logic [63:0]  ref_ins = 64'h0;
  logic         ref_ins_v = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'h0;
  endfunction

  task automatic exp_wr(input logic [63:0] a, input logic [63:0] d);
    exp_mem.push_back({1'b1, a, d});
    ref_mem[a] = d;
  endtask

  // Reference model: what each operation should do to memory and what it answers.
  task automatic model(input logic [2:0] op, input logic [63:0] a, s, n, input int spin);
    logic ok = 1'b0;
    logic [63:0] rs = s, rn = n;
    case (op)
      OP_LOCK: begin
        for (int i = 0; i < spin; i++) begin
          exp_mem.push_back({1'b0, LOCK, 64'h0});
          spin_q.push_back(64'h1);
        end
        exp_mem.push_back({1'b0, LOCK, 64'h0});
        exp_wr(LOCK, 64'h1);
        ok = 1'b1;
      end
      OP_UNLOCK: begin exp_wr(LOCK, 64'h0); ok = 1'b1; end
      OP_LOAD: if (a % 8 == 0) begin
        exp_mem.push_back({1'b0, a, 64'h0});
        exp_mem.push_back({1'b0, a + 64'd8, 64'h0});
        rs = rd(a); rn = rd(a + 64'd8); ok = 1'b1;
      end
      OP_SET: begin ref_ins = a; ref_ins_v = 1'b1; ok = 1'b1; end
      OP_INSERT: if (a % 8 == 0 && ref_ins_v) begin
        exp_wr(a, s); exp_wr(a + 64'd8, n); exp_wr(ref_ins + 64'd8, a); ok = 1'b1;
      end
      OP_DELETE: if (a % 8 == 0) begin exp_wr(a + 64'd8, n); ok = 1'b1; end
      default: ok = 1'b0;
    endcase
    exp_rsp.push_back({a, rs, rn, ok});
  endtask

  task automatic send(input logic [2:0] op, input logic [63:0] a, s, n, input int spin);
    int t = 0;
    model(op, a, s, n, spin);
    req_i = {a, s, n, 1'b1, op};
    forever begin
      @(negedge clk);
      if (req_ready_o) break;
      if (++t > 3000) begin chk("req_accept_timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    req_i[3] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    forever begin
      @(negedge clk);
      if (exp_rsp.size() == 0 && !rsp_valid_o) break;
      if (++t > 3000) begin chk("drain_timeout", exp_rsp.size(), 0); break; end
    end
    @(posedge clk); #1;
  endtask

  // Memory responder plus memory-access scoreboard.
  initial begin
    logic pend = 1'b0;
    int dly = 0, stale_done = 0;
    logic [63:0] rdat = 64'h0;
    logic [128:0] e;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'h0;
    forever begin
      @(negedge clk);
      if (!rst_i && mem_req_o && mem_gnt_i) begin
        grants++;
        if (exp_mem.size() == 0) chk("unexpected_mem_access", {mem_we_o, mem_addr_o}, 0);
        else begin
          e = exp_mem.pop_front();
          chk("mem_access", {mem_we_o, mem_addr_o, mem_we_o ? mem_wdata_o : 64'h0}, e);
        end
        if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
        else if (mem_addr_o == LOCK && spin_q.size() != 0) rdat = spin_q.pop_front();
        else rdat = mem.exists(mem_addr_o) ? mem[mem_addr_o] : 64'h0;
        pend = 1'b1;
        dly = $urandom_range(0, 2);
      end
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0;
      if (rst_i) begin
        pend = 1'b0;
        spin_q.delete();
      end else if (stale_req != stale_done) begin
        stale_done = stale_req;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD_BEEF;
      end else if (pend && !hold_rv) begin
        if (dly == 0) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = rdat; pend = 1'b0;
        end else dly--;
      end
      mem_gnt_i = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready_i = !rsp_hold && ($urandom_range(0, 3) != 0);
    end
  end

  // Response monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i && rsp_valid_o && rsp_ready_i) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", rsp_o, 0);
        else chk("rsp", rsp_o, exp_rsp.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, t;
    logic [192:0] snap;
    logic [63:0] a;
    logic [2:0] op;
    rst_i = 1'b1; req_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp", rsp_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready_o, 1);
    @(posedge clk); #1;

    g0 = grants;
    send(OP_INSERT, 64'h500, 64'h80, 64'h600, 0);
    drain();
    chk("insert_no_base_no_mem", grants - g0, 0);

    mem[64'h100] = 64'h40; ref_mem[64'h100] = 64'h40;
    mem[64'h108] = 64'h200; ref_mem[64'h108] = 64'h200;
    send(OP_LOAD, 64'h100, 64'h0, 64'h0, 0);
    send(OP_LOCK, 64'h0, 64'h0, 64'h0, 2);
    send(OP_UNLOCK, 64'h0, 64'h0, 64'h0, 0);
    send(OP_SET, 64'h300, 64'h0, 64'h0, 0);
    send(OP_INSERT, 64'h500, 64'h80, 64'h600, 0);
    drain();
    chk("insert_link_mem", mem[64'h308], 64'h500);

    g0 = grants;
    rsp_hold = 1'b1;
    send(OP_LOAD, 64'h104, 64'h11, 64'h22, 0);
    t = 0;
    while (!rsp_valid_o && t < 50) begin @(negedge clk); t++; end
    chk("misalign_rsp_seen", rsp_valid_o, 1);
    snap = rsp_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_stable", rsp_o, snap);
      chk("hold_ready_low", req_ready_o, 0);
    end
    rsp_hold = 1'b0;
    drain();
    chk("misalign_no_mem", grants - g0, 0);

    send(OP_LOAD, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 0);
    send(OP_DELETE, 64'h500, 64'h0, 64'h700, 0);
    send(3'd6, 64'h500, 64'h1, 64'h2, 0);
    send(3'd7, 64'h508, 64'h3, 64'h4, 0);
    drain();

    hold_rv = 1'b1;
    g0 = grants;
    send(OP_LOAD, 64'h100, 64'h0, 64'h0, 0);
    t = 0;
    while (grants == g0 && t < 200) begin @(negedge clk); t++; end
    chk("midload_grant_seen", grants > g0, 1);
    @(posedge clk); #3;
    rst_i = 1'b1;
    #1;
    chk("midrst_mem_req", mem_req_o, 0);
    chk("midrst_rsp_valid", rsp_valid_o, 0);
    chk("midrst_rsp", rsp_o, 0);
    chk("midrst_mem_addr", mem_addr_o, 0);
    exp_mem.delete(); exp_rsp.delete();
    ref_ins = 64'h0; ref_ins_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0; hold_rv = 1'b0;
    stale_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stale_no_rsp", rsp_valid_o, 0);
      chk("stale_no_req", mem_req_o, 0);
    end
    @(posedge clk); #1;
    send(OP_LOAD, 64'h100, 64'h0, 64'h0, 0);
    drain();

    for (int i = 0; i < 64; i++) begin
      mem[64'h1000 + 64'(i) * 8] = {$urandom, $urandom};
      ref_mem[64'h1000 + 64'(i) * 8] = mem[64'h1000 + 64'(i) * 8];
    end
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a = 64'h1000 + 64'($urandom_range(0, 31)) * 8;
      if ($urandom_range(0, 7) == 0) a = a + 64'($urandom_range(1, 7));
      if (op == OP_LOCK && rd(LOCK) != 64'h0) op = OP_UNLOCK;
      send(op, a, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 2));
    end
    drain();
    chk("exp_mem_empty", exp_mem.size(), 0);
    chk("exp_rsp_empty", exp_rsp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
